// File: rtl/ebi_master.sv
// Single-word EBI initiator: turns read/write requests into timed cs/rd/wr cycles.
// Outputs are registered from the next state, so the bus changes on the edge after a decision.
module ebi_master #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ebi_addr,
  inout  wire  [DATA_W-1:0] ebi_data,
  output logic              ebi_cs,
  output logic              ebi_rd,
  output logic              ebi_wr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  // Load values are only used when the matching phase is enabled.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              wr_q, wr_nxt;
  logic [DATA_W-1:0] wdata_q;
  logic              data_oe;

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_q;
    cnt_nxt   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          wr_nxt    = req_write;
          state_nxt = (SETUP_CYC > 0) ? S_SETUP : S_STROBE;
        end
      end
      S_SETUP:  if (cnt == 4'd0) state_nxt = S_STROBE;
      S_STROBE: if (cnt == 4'd0) state_nxt = (HOLD_CYC > 0) ? S_HOLD : S_IDLE;
      S_HOLD:   if (cnt == 4'd0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) begin
      case (state_nxt)
        S_SETUP:  cnt_nxt = SETUP_LD;
        S_STROBE: cnt_nxt = STROBE_LD;
        S_HOLD:   cnt_nxt = HOLD_LD;
        default:  cnt_nxt = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      data_oe   <= 1'b0;
      ebi_addr  <= '0;
      ebi_cs    <= 1'b0;
      ebi_rd    <= 1'b0;
      ebi_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wr_q  <= wr_nxt;
      if (state == S_IDLE && req_valid) begin
        ebi_addr <= req_addr;
        wdata_q  <= req_wdata;
      end
      ebi_cs    <= (state_nxt != S_IDLE);
      ebi_rd    <= (state_nxt == S_STROBE) && !wr_nxt;
      ebi_wr    <= (state_nxt == S_STROBE) && wr_nxt;
      data_oe   <= (state_nxt != S_IDLE) && wr_nxt;
      busy      <= (state_nxt != S_IDLE);
      req_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state != S_IDLE) && (state_nxt == S_IDLE);
      // Last strobe cycle of a read: the responder is still driving here.
      if (state == S_STROBE && cnt == 4'd0 && !wr_q)
        rsp_rdata <= ebi_data;
    end
  end

  assign ebi_data = data_oe ? wdata_q : {DATA_W{1'bz}};

endmodule
